// File: rtl/updown_counter_pkg.sv
// Shared types and parameter checks for the modulo up/down counter.
// The saturating variant is selected with UPDOWN_COUNTER_SAT_EN (see updown_counter_next).
package updown_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Step magnitudes must never exceed the modulus, so a single wrap/clamp suffices.
  function automatic bit params_legal(input int w, input int max, input int sw);
    bit ok;
    ok = 1'b1;
    if (w < 1 || w > 30) ok = 1'b0;
    if (sw < 1 || sw > 30) ok = 1'b0;
    if (ok) begin
      if (max < 1 || max > ((1 << w) - 1)) ok = 1'b0;
      if (((1 << sw) - 1) > max) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and wrap/clamp flag for the up/down counter.
// UPDOWN_COUNTER_SAT_EN defined: clamp at 0/MAX instead of wrapping modulo MAX+1.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MAX = 2**W - 1,
  parameter int SW  = 2
) (
  input  logic [W-1:0]  cur_i,
  input  logic [SW-1:0] step_i,
  input  logic          down_i,
  output logic [W-1:0]  nxt_o,
  output logic          wrap_o
);

  localparam logic [W:0] MAX_X = (W+1)'(MAX);
  localparam logic [W:0] MOD_X = (W+1)'(MAX + 1);

  dir_e       dir;
  logic [W:0] cur_x;
  logic [W:0] step_x;
  logic [W:0] sum;

  // Everything is widened by one bit so the carry is visible before comparing.
  assign dir    = dir_e'(down_i);
  assign cur_x  = {1'b0, cur_i};
  assign step_x = (W+1)'(step_i);
  assign sum    = cur_x + step_x;

  always_comb begin
    nxt_o  = cur_i;
    wrap_o = 1'b0;
    if (dir == DIR_UP) begin
      if (sum > MAX_X) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        nxt_o = W'(MAX_X);
`else
        nxt_o = W'(sum - MOD_X);
`endif
        wrap_o = 1'b1;
      end else begin
        nxt_o = W'(sum);
      end
    end else begin
      if (step_x > cur_x) begin
`ifdef UPDOWN_COUNTER_SAT_EN
        nxt_o = '0;
`else
        nxt_o = W'(cur_x + MOD_X - step_x);
`endif
        wrap_o = 1'b1;
      end else begin
        nxt_o = W'(cur_x - step_x);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised modulo up/down counter with variable step, parallel load and wrap flag.
// Define UPDOWN_COUNTER_SAT_EN for the saturating (clamp) variant.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MAX = 2**W - 1,
  parameter int SW  = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          en,
  input  logic          down,
  input  logic [SW-1:0] step,
  input  logic          load,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  out,
  output logic          wrap,
  output logic          zero
);

  localparam logic [W:0] MAX_X = (W+1)'(MAX);

  if (!params_legal(W, MAX, SW)) begin : g_bad_params
    $error("updown_counter_mod: illegal W/MAX/SW combination");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         zero_q;
  logic [W-1:0] cnt_nxt;
  logic         cnt_wrap;
  logic [W-1:0] din_clamp;

  updown_counter_next #(
    .W   (W),
    .MAX (MAX),
    .SW  (SW)
  ) u_next (
    .cur_i  (cnt_q),
    .step_i (step),
    .down_i (down),
    .nxt_o  (cnt_nxt),
    .wrap_o (cnt_wrap)
  );

  assign din_clamp = ({1'b0, din} > MAX_X) ? W'(MAX_X) : din;

  // Load beats enable; a zero step is treated as hold.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = din_clamp;
    end else if (en && (step != '0)) begin
      cnt_d  = cnt_nxt;
      wrap_d = cnt_wrap;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign out  = cnt_q;
  assign wrap = wrap_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Randomised and directed bench for updown_counter_mod (W=4, MAX=9, SW=2).
module tb_updown_counter_mod;

  localparam int W   = 4;
  localparam int MAX = 9;
  localparam int SW  = 2;

  logic          clk;
  logic          nrst;
  logic          en;
  logic          down;
  logic [SW-1:0] step;
  logic          load;
  logic [W-1:0]  din;
  logic [W-1:0]  out;
  logic          wrap;
  logic          zero;

  int n_total;
  int n_pass;

  int m_out;
  int m_wrap;

  updown_counter_mod #(
    .W   (W),
    .MAX (MAX),
    .SW  (SW)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .down (down),
    .step (step),
    .load (load),
    .din  (din),
    .out  (out),
    .wrap (wrap),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference behaviour expressed directly as modular / clamped arithmetic.
  task automatic model_update(input int e, input int d, input int s, input int l, input int di);
    int mod;
    int raw;
    mod = MAX + 1;
    if (l != 0) begin
      m_out  = (di > MAX) ? MAX : di;
      m_wrap = 0;
    end else if (e != 0 && s != 0) begin
      raw = (d != 0) ? (m_out - s) : (m_out + s);
      m_wrap = (raw < 0 || raw > MAX) ? 1 : 0;
`ifdef UPDOWN_COUNTER_SAT_EN
      m_out = (raw < 0) ? 0 : ((raw > MAX) ? MAX : raw);
`else
      m_out = ((raw % mod) + mod) % mod;
`endif
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"},  int'(out),  m_out);
    check({tag, ".wrap"}, int'(wrap), m_wrap);
    check({tag, ".zero"}, int'(zero), (m_out == 0) ? 1 : 0);
  endtask

  task automatic cyc(input logic e, input logic d, input int s, input logic l, input int di);
    @(negedge clk);
    nrst = 1'b1;
    en   = e;
    down = d;
    step = SW'(s);
    load = l;
    din  = W'(di);
    @(posedge clk);
    model_update(int'(e), int'(d), s, int'(l), di);
    #1;
    compare_all("cyc");
  endtask

  // Literal expectation: pins both the DUT and the model to a hand-worked value.
  task automatic lit(input string name, input int exp_out, input int exp_wrap);
    check({name, ".dut_out"},   int'(out),  exp_out);
    check({name, ".dut_wrap"},  int'(wrap), exp_wrap);
    check({name, ".model_out"}, m_out,      exp_out);
  endtask

  task automatic async_reset(input string tag);
    #2;
    nrst = 1'b0;
    #1;
    m_out  = 0;
    m_wrap = 0;
    compare_all(tag);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    m_out   = 0;
    m_wrap  = 0;
    nrst = 1'b0;
    en   = 1'b0;
    down = 1'b0;
    step = '0;
    load = 1'b0;
    din  = '0;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    lit("reset", 0, 0);

    // Scenario 1: async reset from 7 between edges
    cyc(1'b0, 1'b0, 0, 1'b1, 7);
    lit("load7", 7, 0);
    async_reset("async_rst");
    lit("async_rst", 0, 0);
    check("async_rst.zero", int'(zero), 1);

    // Scenario 4: load priority and clamp
    cyc(1'b1, 1'b0, 1, 1'b1, 5);
    lit("load5", 5, 0);
    cyc(1'b1, 1'b1, 3, 1'b1, 12);
    lit("load12", 9, 0);

    // Scenario 5: hold
    cyc(1'b0, 1'b0, 0, 1'b1, 4);
    cyc(1'b0, 1'b0, 1, 1'b0, 0);
    cyc(1'b0, 1'b1, 3, 1'b0, 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0);
    lit("hold", 4, 0);
    cyc(1'b1, 1'b0, 1, 1'b0, 0);
    lit("hold_then_up", 5, 0);

`ifndef UPDOWN_COUNTER_SAT_EN
    // Scenario 2: up by 2 from 6
    cyc(1'b0, 1'b0, 0, 1'b1, 6);
    cyc(1'b1, 1'b0, 2, 1'b0, 0);
    lit("up2_a", 8, 0);
    cyc(1'b1, 1'b0, 2, 1'b0, 0);
    lit("up2_b", 0, 1);
    check("up2_b.zero", int'(zero), 1);
    cyc(1'b1, 1'b0, 2, 1'b0, 0);
    lit("up2_c", 2, 0);

    // Scenario 3: down across zero
    cyc(1'b0, 1'b0, 0, 1'b1, 1);
    cyc(1'b1, 1'b1, 3, 1'b0, 0);
    lit("dn3_a", 8, 1);
    cyc(1'b1, 1'b1, 3, 1'b0, 0);
    lit("dn3_b", 5, 0);
    cyc(1'b0, 1'b0, 0, 1'b1, 1);
    cyc(1'b1, 1'b1, 1, 1'b0, 0);
    lit("dn1_a", 0, 0);
    cyc(1'b1, 1'b1, 1, 1'b0, 0);
    lit("dn1_b", 9, 1);
    cyc(1'b1, 1'b1, 1, 1'b0, 0);
    lit("dn1_c", 8, 0);
`else
    // Scenario 6: saturating behaviour
    cyc(1'b0, 1'b0, 0, 1'b1, 8);
    cyc(1'b1, 1'b0, 2, 1'b0, 0);
    lit("sat_up_a", 9, 1);
    cyc(1'b1, 1'b0, 2, 1'b0, 0);
    lit("sat_up_b", 9, 1);
    cyc(1'b0, 1'b0, 0, 1'b1, 1);
    cyc(1'b1, 1'b1, 3, 1'b0, 0);
    lit("sat_dn", 0, 1);
    cyc(1'b0, 1'b0, 0, 1'b1, 8);
    cyc(1'b1, 1'b0, 1, 1'b0, 0);
    lit("sat_exact", 9, 0);
`endif

    // Randomised traffic with occasional mid-cycle async reset
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
          int'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
